line_reg_responder: RTL and testbench
=====================================

// Module: line_reg_responder
// PURPOSE
//  Responder side of the host register interface (address/write/write_data/read_data) used by the
//  vector-display host. Holds line endpoints, beam intensity, decay mode and a PRNG; on a GO write
//  runs a Bresenham line engine that streams pixel writes to the framebuffer port with valid/ready.
//  Sits between the host bus and the framebuffer/decay logic, all on the pixel clock domain.
// PARAMETERS
//  CW        8      coordinate width (bits) for x and y
//  LFSR_SEED 8'h01  PRNG value after reset, and after a zero seed write
// PORTS
//  pclk        in   1     pixel clock; all logic on posedge
//  rst_n       in   1     synchronous reset, active-low
//  address     in   3     register select: 0 STAX,1 STAY,2 ENDX,3 ENDY,4 BUSY,5 BEAM,6 MODE,7 PRNG
//  write       in   1     write strobe, sampled on posedge pclk
//  write_data  in   8     write data
//  read_data   out  8     registered read data for address
//  beam        out  4     current beam intensity (BEAM[3:0])
//  mode        out  2     decay mode: 0 hold,1 clear,2 linear,3 exponential
//  pix_x       out  CW    pixel x
//  pix_y       out  CW    pixel y
//  pix_i       out  4     pixel intensity, latched from BEAM at GO
//  pix_valid   out  1     pixel valid
//  pix_ready   in   1     framebuffer accepts pixel when pix_valid && pix_ready
// BEHAVIOUR
//  Reset (rst_n low at posedge, any state incl. mid-line): STAX..ENDY=0, BEAM=0, MODE=0,
//   PRNG=LFSR_SEED, read_data=0, pix_valid=0, pix_x/pix_y=0, pix_i=0, engine IDLE, busy=0.
//  Writes: on posedge with write=1, reg[address]<=write_data (BEAM keeps [3:0], MODE keeps [1:0]).
//   Coordinate writes while busy are stored but do not affect the running line.
//  BUSY write: data[0]=1 while IDLE -> GO; data[0]=1 while busy ignored; data[0]=0 no effect.
//  PRNG write: seeds LFSR; value 0 loads LFSR_SEED. Otherwise LFSR advances every cycle,
//   Fibonacci x^8+x^6+x^5+x^4+1, shift left, new bit0 = b7^b5^b4^b3.
//  read_data: updated every posedge from address at that edge (1-cycle latency, no write needed).
//   Addr 0-3 stored coord; 4 = {7'b0,busy}; 5 = {4'b0,BEAM}; 6 = {6'b0,MODE}; 7 = LFSR value.
//  FSM IDLE -> SETUP -> DRAW -> IDLE.
//   IDLE: busy=0. GO at edge N latches sx,sy,ex,ey,pix_i; enter SETUP; busy reads 1 from edge N+1.
//   SETUP (1 cycle): dx=|ex-sx|, dy=-|ey-sy|, stepx/stepy=+/-1, err=dx+dy (CW+2 bit signed);
//    pix_x=sx, pix_y=sy, pix_valid=1 at edge N+2; enter DRAW.
//   DRAW: pix_x/pix_y/pix_valid held stable while pix_valid && !pix_ready.
//    On handshake: if pix_x==ex && pix_y==ey -> pix_valid=0, IDLE (busy reads 0 next read).
//    Else e2=2*err; if e2>=dy {err+=dy; x+=stepx}; if e2<=dx {err+=dx; y+=stepy}; both use
//    pre-update err; next pixel valid the cycle after handshake, or same-cycle back-to-back.
//  Pixel count per line = max(|ex-sx|,|ey-sy|)+1; start==end emits exactly 1 pixel.
//  Coordinates never wrap: arithmetic in CW+2 signed, stepping stops exactly at end point.
//  Simultaneous GO write and handshake cannot occur (GO only honoured in IDLE).
// TESTING
//  1 Reset: hold rst_n low 2 cycles, read all 8 addrs -> 0,0,0,0,0,0,0,01 (PRNG after 1 step ok
//    if bench accounts); pix_valid=0.
//  2 Vertical: STAX=128,STAY=126,ENDX=128,ENDY=100, GO, pix_ready=1 -> 27 pixels x=128,
//    y=126..100 descending; BUSY reads 01 during, 00 after.
//  3 Shallow: 40,128 -> 80,100 -> 41 pixels, x 40..80 monotonic, y 128..100, last=(80,100);
//    matches reference Bresenham model pixel-for-pixel; pix_i = BEAM at GO (0x7).
//  4 Backpressure: diagonal 130,130 -> 156,156 with pix_ready random 50% -> 27 pixels (k,k),
//    outputs stable while stalled, no drop/duplicate; GO written mid-line ignored; STAX write
//    mid-line does not change current line.
//  5 Point and reset mid-line: 50,50->50,50 -> 1 pixel, busy 1 for 2-3 cycles; start 0,0->255,255,
//    assert rst_n low after 10 pixels -> pix_valid=0, busy=0 next cycle, no further pixels.
//  6 Regs/PRNG: write BEAM=0xFF -> reads 0x0F; MODE=0x03 -> mode=3; PRNG seed 0x00 -> then
//    reads follow LFSR from 0x01; seed 0xA5 -> sequence matches model, never 0x00.

Source files
------------

// File: rtl/line_reg_responder.sv
// Host-facing register block with a Bresenham line engine that streams pixels to the framebuffer.
// Register writes and the LFSR run every cycle; the engine latches its endpoints when a GO write arrives.
module line_reg_responder #(
   parameter int          CW        = 8,
   parameter logic [7:0]  LFSR_SEED = 8'h01
) (
   input  logic          pclk,
   input  logic          rst_n,
   input  logic [2:0]    address,
   input  logic          write,
   input  logic [7:0]    write_data,
   output logic [7:0]    read_data,
   output logic [3:0]    beam,
   output logic [1:0]    mode,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic [3:0]    pix_i,
   output logic          pix_valid,
   input  logic          pix_ready
);

   typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t state, state_nx;

   logic [CW-1:0] sta_x, sta_y, end_x, end_y;
   logic [3:0]    beam_r;
   logic [1:0]    mode_r;
   logic [7:0]    lfsr;
   logic [7:0]    rd_mux;
   logic          busy;
   logic          go;

   logic [CW-1:0]        sx, sy, ex, ey;
   logic [CW-1:0]        sx_nx, sy_nx, ex_nx, ey_nx;
   logic signed [CW+1:0] dx, dy, err;
   logic signed [CW+1:0] dx_nx, dy_nx, err_nx;
   logic                 step_xn, step_yn, step_xn_nx, step_yn_nx;
   logic [CW-1:0]        pix_x_nx, pix_y_nx;
   logic [3:0]           pix_i_nx;
   logic                 pix_valid_nx;

   logic signed [CW+1:0] dx_raw, dy_raw, dx_abs, dy_abs, e2, err_acc;

   assign busy = (state != IDLE);
   assign go   = write && (address == 3'd4) && write_data[0] && (state == IDLE);
   assign beam = beam_r;
   assign mode = mode_r;

   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0: rd_mux = 8'(sta_x);
         3'd1: rd_mux = 8'(sta_y);
         3'd2: rd_mux = 8'(end_x);
         3'd3: rd_mux = 8'(end_y);
         3'd4: rd_mux = {7'b0, busy};
         3'd5: rd_mux = {4'b0, beam_r};
         3'd6: rd_mux = {6'b0, mode_r};
         3'd7: rd_mux = lfsr;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         sta_x     <= '0;
         sta_y     <= '0;
         end_x     <= '0;
         end_y     <= '0;
         beam_r    <= '0;
         mode_r    <= '0;
         lfsr      <= LFSR_SEED;
         read_data <= '0;
      end else begin
         if (write) begin
            case (address)
               3'd0: sta_x  <= CW'(write_data);
               3'd1: sta_y  <= CW'(write_data);
               3'd2: end_x  <= CW'(write_data);
               3'd3: end_y  <= CW'(write_data);
               3'd5: beam_r <= write_data[3:0];
               3'd6: mode_r <= write_data[1:0];
               default: ;
            endcase
         end
         // A zero seed would lock the LFSR, so it is replaced by the reset seed.
         if (write && (address == 3'd7))
            lfsr <= (write_data == '0) ? LFSR_SEED : write_data;
         else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         read_data <= rd_mux;
      end
   end

   always_comb begin
      state_nx     = state;
      sx_nx        = sx;
      sy_nx        = sy;
      ex_nx        = ex;
      ey_nx        = ey;
      dx_nx        = dx;
      dy_nx        = dy;
      err_nx       = err;
      step_xn_nx   = step_xn;
      step_yn_nx   = step_yn;
      pix_x_nx     = pix_x;
      pix_y_nx     = pix_y;
      pix_i_nx     = pix_i;
      pix_valid_nx = pix_valid;

      dx_raw  = $signed({2'b00, ex}) - $signed({2'b00, sx});
      dy_raw  = $signed({2'b00, ey}) - $signed({2'b00, sy});
      dx_abs  = dx_raw[CW+1] ? -dx_raw : dx_raw;
      dy_abs  = dy_raw[CW+1] ? -dy_raw : dy_raw;
      e2      = err <<< 1;
      err_acc = err;

      case (state)
         IDLE: begin
            if (go) begin
               sx_nx    = sta_x;
               sy_nx    = sta_y;
               ex_nx    = end_x;
               ey_nx    = end_y;
               pix_i_nx = beam_r;
               state_nx = SETUP;
            end
         end
         SETUP: begin
            dx_nx      = dx_abs;
            dy_nx      = -dy_abs;
            err_nx     = dx_abs - dy_abs;
            step_xn_nx = (ex < sx);
            step_yn_nx = (ey < sy);
            state_nx   = DRAW;
         end
         DRAW: begin
            // First DRAW cycle presents the start point; afterwards each handshake advances.
            if (!pix_valid) begin
               pix_x_nx     = sx;
               pix_y_nx     = sy;
               pix_valid_nx = 1'b1;
            end else if (pix_ready) begin
               if ((pix_x == ex) && (pix_y == ey)) begin
                  pix_valid_nx = 1'b0;
                  state_nx     = IDLE;
               end else begin
                  if (e2 >= dy) begin
                     err_acc  = err_acc + dy;
                     pix_x_nx = step_xn ? pix_x - ONE : pix_x + ONE;
                  end
                  if (e2 <= dx) begin
                     err_acc  = err_acc + dx;
                     pix_y_nx = step_yn ? pix_y - ONE : pix_y + ONE;
                  end
                  err_nx = err_acc;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sx        <= '0;
         sy        <= '0;
         ex        <= '0;
         ey        <= '0;
         dx        <= '0;
         dy        <= '0;
         err       <= '0;
         step_xn   <= 1'b0;
         step_yn   <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_i     <= '0;
         pix_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         sx        <= sx_nx;
         sy        <= sy_nx;
         ex        <= ex_nx;
         ey        <= ey_nx;
         dx        <= dx_nx;
         dy        <= dy_nx;
         err       <= err_nx;
         step_xn   <= step_xn_nx;
         step_yn   <= step_yn_nx;
         pix_x     <= pix_x_nx;
         pix_y     <= pix_y_nx;
         pix_i     <= pix_i_nx;
         pix_valid <= pix_valid_nx;
      end
   end

endmodule

// File: tb/tb_line_reg_responder.sv
// Bench for line_reg_responder: register reads, LFSR sequence, and pixel streams scored
// against a Bresenham reference whose pixels are queued when GO is written.
module tb_line_reg_responder;

   logic       pclk = 1'b0;
   logic       rst_n;
   logic [2:0] address;
   logic       write;
   logic [7:0] write_data;
   logic [7:0] read_data;
   logic [3:0] beam;
   logic [1:0] mode;
   logic [7:0] pix_x, pix_y;
   logic [3:0] pix_i;
   logic       pix_valid;
   logic       pix_ready = 1'b0;

   logic rnd_ready = 1'b0;
   logic fix_ready = 1'b0;

   typedef struct { int x; int y; int i; } pix_t;
   pix_t sb[$];

   int n_cmp = 0;
   int n_err = 0;
   int hs_count = 0;
   int last_x, last_y;
   int beam_m = 0;

   logic       stall_prev = 1'b0;
   logic [7:0] hx, hy;
   logic [3:0] hi;

   line_reg_responder #(.CW(8), .LFSR_SEED(8'h01)) dut (
      .pclk(pclk), .rst_n(rst_n), .address(address), .write(write),
      .write_data(write_data), .read_data(read_data), .beam(beam), .mode(mode),
      .pix_x(pix_x), .pix_y(pix_y), .pix_i(pix_i), .pix_valid(pix_valid),
      .pix_ready(pix_ready)
   );

   always #5 pclk = ~pclk;

   always @(negedge pclk) pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic push_line(input int sx, input int sy, input int ex, input int ey);
      int dx, dy, err, e2, x, y, stx, sty;
      pix_t p;
      dx  = iabs(ex - sx);
      dy  = -iabs(ey - sy);
      stx = (sx < ex) ? 1 : -1;
      sty = (sy < ey) ? 1 : -1;
      err = dx + dy;
      x   = sx;
      y   = sy;
      forever begin
         p.x = x; p.y = y; p.i = beam_m;
         sb.push_back(p);
         if (x == ex && y == ey) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += stx; end
         if (e2 <= dx) begin err += dx; y += sty; end
      end
   endtask

   // Pixel monitor: a handshake seen here completes on the following posedge.
   always @(negedge pclk) begin
      pix_t e;
      #1;
      if (rst_n) begin
         if (stall_prev)
            check("stall_hold", 32'({pix_valid, pix_x, pix_y, pix_i}), 32'({1'b1, hx, hy, hi}));
         if (pix_valid && pix_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
               check("pix_extra", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               check("pix_x", 32'(pix_x), 32'(e.x));
               check("pix_y", 32'(pix_y), 32'(e.y));
               check("pix_i", 32'(pix_i), 32'(e.i));
            end
            last_x = int'(pix_x);
            last_y = int'(pix_y);
         end
         stall_prev = pix_valid && !pix_ready;
         hx = pix_x; hy = pix_y; hi = pix_i;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      address = a; write = 1'b1; write_data = d;
      @(negedge pclk);
      write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
      address = a; write = 1'b0;
      @(negedge pclk);
      check(tag, 32'(read_data), 32'(exp));
   endtask

   task automatic set_line(input int sx, input int sy, input int ex, input int ey);
      wr(3'd0, 8'(sx)); wr(3'd1, 8'(sy)); wr(3'd2, 8'(ex)); wr(3'd3, 8'(ey));
   endtask

   task automatic wait_done(input int budget);
      bit done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge pclk);
         #2;
         if (sb.size() == 0 && !pix_valid) done = 1'b1;
      end
      if (!done) begin
         check("timeout_sb", 32'(sb.size()), 32'd0);
         check("timeout_valid", 32'(pix_valid), 32'd0);
      end
   endtask

   task automatic wait_hs(input int n, input int budget);
      bit done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge pclk);
         #2;
         if (hs_count >= n) done = 1'b1;
      end
      if (!done) check("timeout_hs", 32'(hs_count), 32'(n));
   endtask

   task automatic run_line(input int sx, input int sy, input int ex, input int ey, input int n,
                           input string tag);
      set_line(sx, sy, ex, ey);
      push_line(sx, sy, ex, ey);
      hs_count = 0;
      wr(3'd4, 8'h01);
      rd(3'd4, 8'h01, {tag, "_busy_run"});
      wait_done(2000);
      rd(3'd4, 8'h00, {tag, "_busy_done"});
      check({tag, "_count"}, 32'(hs_count), 32'(n));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] m;
      int nb, hs_hold;

      rst_n = 1'b0; address = '0; write = 1'b0; write_data = '0;
      repeat (3) @(negedge pclk);
      check("rst_rdata", 32'(read_data), 32'd0);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_pix", 32'({pix_x, pix_y, pix_i}), 32'd0);
      address = 3'd7;
      rst_n   = 1'b1;
      @(negedge pclk);
      check("rst_prng", 32'(read_data), 32'h01);
      for (int a = 0; a < 7; a++) rd(3'(a), 8'h00, "rst_reg");

      // Vertical line upward in y, constant x.
      fix_ready = 1'b1;
      run_line(128, 126, 128, 100, 27, "vert");

      // Shallow line with beam latched at GO.
      wr(3'd5, 8'h07); beam_m = 7;
      run_line(40, 128, 80, 100, 41, "shallow");
      check("shallow_last", 32'({last_x[15:0], last_y[15:0]}), {16'd80, 16'd100});

      // Diagonal under random backpressure; GO and STAX writes mid-line.
      wr(3'd5, 8'h03); beam_m = 3;
      rnd_ready = 1'b1;
      set_line(130, 130, 156, 156);
      push_line(130, 130, 156, 156);
      hs_count = 0;
      wr(3'd4, 8'h01);
      wait_hs(5, 500);
      wr(3'd4, 8'h01);
      wr(3'd0, 8'h05);
      rd(3'd4, 8'h01, "bp_busy_mid");
      wait_done(2000);
      rd(3'd4, 8'h00, "bp_busy_done");
      check("bp_count", 32'(hs_count), 32'd27);
      rd(3'd0, 8'h05, "bp_stax_stored");
      rnd_ready = 1'b0;
      repeat (5) @(negedge pclk);
      check("bp_no_restart", 32'(hs_count), 32'd27);

      // Single-point line.
      set_line(50, 50, 50, 50);
      push_line(50, 50, 50, 50);
      hs_count = 0;
      wr(3'd4, 8'h01);
      nb = 0;
      for (int k = 0; k < 6; k++) begin
         address = 3'd4;
         @(negedge pclk);
         if (read_data[0]) nb++;
      end
      check("point_busy_cycles", 32'((nb >= 2) && (nb <= 3)), 32'd1);
      wait_done(100);
      check("point_count", 32'(hs_count), 32'd1);

      // Reset in the middle of a long line.
      set_line(0, 0, 255, 255);
      push_line(0, 0, 255, 255);
      hs_count = 0;
      wr(3'd4, 8'h01);
      wait_hs(10, 200);
      rst_n = 1'b0;
      @(negedge pclk);
      check("midrst_valid", 32'(pix_valid), 32'd0);
      hs_hold = hs_count;
      sb.delete();
      beam_m = 0;
      rst_n = 1'b1;
      rd(3'd4, 8'h00, "midrst_busy");
      repeat (20) @(negedge pclk);
      check("midrst_no_pix", 32'(hs_count), 32'(hs_hold));
      check("midrst_valid_after", 32'(pix_valid), 32'd0);

      // Register masking and outputs.
      wr(3'd5, 8'hFF);
      rd(3'd5, 8'h0F, "beam_read");
      check("beam_port", 32'(beam), 32'hF);
      wr(3'd6, 8'h03);
      check("mode_port", 32'(mode), 32'd3);
      rd(3'd6, 8'h03, "mode_read");

      // PRNG: zero seed falls back to 0x01, then a nonzero seed.
      wr(3'd7, 8'h00);
      m = 8'h01;
      for (int k = 0; k < 8; k++) begin
         @(negedge pclk);
         check("prng_zero_seed", 32'(read_data), 32'(m));
         m = lfsr_next(m);
      end
      wr(3'd7, 8'hA5);
      m = 8'hA5;
      for (int k = 0; k < 20; k++) begin
         @(negedge pclk);
         check("prng_a5", 32'(read_data), 32'(m));
         check("prng_nonzero", 32'(read_data != 8'h00), 32'd1);
         m = lfsr_next(m);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
